// File: rtl/md_pkg.sv
// Shared encodings and constants for the MIPS32 multiply/divide unit.
package md_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam logic [4:0]  ITER_LAST = 5'd31;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } md_mode_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
interface muldiv_unit_if;
    import md_pkg::*;

    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             hilo_rd;
    logic             hilo_sel;
    logic [WIDTH-1:0] hilo_rdata;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, md_op, src_a, src_b, flush, hilo_rd, hilo_sel,
        input  hilo_rdata, busy, stall, done
    );

    modport slave (
        input  start, md_op, src_a, src_b, flush, hilo_rd, hilo_sel,
        output hilo_rdata, busy, stall, done
    );

endinterface

// File: rtl/md_iter_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
module md_iter_step
    import md_pkg::*;
(
    input  md_mode_e         mode_i,
    input  logic [63:0]      acc_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             bit_i,
    output logic [63:0]      acc_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_o   = acc_i;
        rem_o   = rem_i;
        qbit_o  = 1'b0;
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, opnd_i};
        if (mode_i == MODE_MUL) begin
            acc_o = (acc_i << 1) + {32'b0, (bit_i ? opnd_i : '0)};
        end else begin
            // Partial remainder stays below 2*divisor, so bit 32 of diff is the borrow.
            qbit_o = ~diff[WIDTH];
            rem_o  = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers.
module muldiv_unit
    import md_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave md
);

    md_state_e        state_q;
    logic [4:0]       cnt_q;
    logic [63:0]      acc_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    md_mode_e         mode_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    md_op_e           op_e;
    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [63:0]      acc_step;
    logic [WIDTH-1:0] rem_d;
    logic             qbit;
    logic [63:0]      acc_d;
    logic [63:0]      prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        op_e      = md_op_e'(md.md_op);
        signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
        sign_a    = signed_op & md.src_a[WIDTH-1];
        sign_b    = signed_op & md.src_b[WIDTH-1];
        mag_a     = sign_a ? -md.src_a : md.src_a;
        mag_b     = sign_b ? -md.src_b : md.src_b;
    end

    // Multiplier bits (mul) and dividend bits (div) both come MSB-first from a_q.
    md_iter_step u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .opnd_i (b_q),
        .bit_i  (a_q[cnt_q]),
        .acc_o  (acc_step),
        .rem_o  (rem_d),
        .qbit_o (qbit)
    );

    always_comb begin
        acc_d    = (mode_q == MODE_DIV) ? {acc_q[62:0], qbit} : acc_step;
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = div0_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= MODE_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md.flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (md.start) begin
                            case (op_e)
                                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                    state_q   <= S_CALC;
                                    cnt_q     <= ITER_LAST;
                                    acc_q     <= '0;
                                    rem_q     <= '0;
                                    a_q       <= mag_a;
                                    b_q       <= mag_b;
                                    mode_q    <= (op_e == MD_DIV || op_e == MD_DIVU) ? MODE_DIV : MODE_MUL;
                                    neg_res_q <= sign_a ^ sign_b;
                                    neg_rem_q <= sign_a;
                                    div0_q    <= (md.src_b == '0);
                                end
                                MD_MTHI: hi_q <= md.src_a;
                                MD_MTLO: lo_q <= md.src_a;
                                default: ;
                            endcase
                        end
                    end
                    S_CALC: begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                    S_FIX: begin
                        if (mode_q == MODE_MUL) begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign md.busy       = (state_q != S_IDLE);
    assign md.done       = done_q;
    assign md.stall      = md.busy & (md.start | md.hilo_rd);
    assign md.hilo_rdata = md.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic clk;
    logic rst_n;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'd3: begin
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic read_check(input string tag);
        bus.hilo_rd  = 1'b1;
        bus.hilo_sel = 1'b0;
        #1;
        check({tag, "_lo"}, bus.hilo_rdata, m_lo);
        check({tag, "_stall_idle"}, {31'b0, bus.stall}, 32'd0);
        bus.hilo_sel = 1'b1;
        #1;
        check({tag, "_hi"}, bus.hilo_rdata, m_hi);
        bus.hilo_rd  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit mid_mthi);
        int unsigned cyc;
        int unsigned stall_bad;
        int unsigned done_busy;
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b1;
        cyc = 0; stall_bad = 0; done_busy = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (!bus.stall) stall_bad++;
            if (bus.done) done_busy++;
            if (mid_mthi && cyc == 5) begin
                bus.start = 1'b1; bus.md_op = 3'd4; bus.src_a = 32'hA5A5A5A5;
            end
            if (mid_mthi && cyc == 7) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b0;
        check({tag, "_busy_cycles"}, cyc, 32'd33);
        check({tag, "_stall_busy"}, stall_bad, 32'd0);
        check({tag, "_done_early"}, done_busy, 32'd0);
        check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd1);
        ref_md(op, a, b);
        @(posedge clk); #1;
        check({tag, "_done_clear"}, {31'b0, bus.done}, 32'd0);
        read_check(tag);
    endtask

    task automatic move_op(input string tag, input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        ref_md(op, a, 32'd0);
        read_check(tag);
    endtask

    task automatic flush_test();
        int unsigned done_seen;
        bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'h0000_1234; bus.src_b = 32'h0000_5678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'b0, bus.busy}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            @(posedge clk); #1;
        end
        check("flush_no_done", done_seen, 32'd0);
        read_check("flush");
        bus.start = 1'b1; bus.md_op = 3'd5; bus.src_a = 32'hDEADBEEF; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        read_check("flush_mtlo");
    endtask

    task automatic reset_test();
        bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'h7654_3210; bus.src_b = 32'h0000_0013;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        m_hi = '0; m_lo = '0;
        read_check("rst");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_after_busy", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.md_op = '0; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0; bus.hilo_rd = 1'b0; bus.hilo_sel = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        read_check("reset");

        run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult_neg_hi_const", m_hi, 32'hFFFFFFFF);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 1'b0);
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 1'b0);
        run_op("div_by0", 3'd2, 32'h12345678, 32'd0, 1'b0);
        run_op("div_neg_by0", 3'd2, 32'h87654321, 32'd0, 1'b0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("mid_mthi", 3'd1, 32'h0001_0003, 32'h0000_0100, 1'b1);
        move_op("mthi", 3'd4, 32'hA5A5A5A5);
        move_op("mtlo", 3'd5, 32'h5A5A0F0F);
        move_op("rsvd", 3'd6, 32'h11111111);
        flush_test();

        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0
               : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (op <= 3'd3) run_op("rand_md", op, a, b, 1'b0);
            else move_op("rand_mv", op, a);
        end

        reset_test();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1);
    end

endmodule
